chunk_serial_adder: RTL and testbench
=====================================

CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be a multiple of CHUNK and at least 2.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; SHALL be at least 1.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, request to begin an operation; sampled only in IDLE or DONE.
REQ-006 Port a, input, WIDTH, operand A; two's complement for overflow purposes.
REQ-007 Port b, input, WIDTH, operand B.
REQ-008 Port cin, input, 1, carry-in (add) or borrow-in (subtract).
REQ-009 Port sub, input, 1, mode select: 0 computes a+b+cin, 1 computes a-b-cin.
REQ-010 Port busy, output, 1, high while an operation is in progress.
REQ-011 Port done, output, 1, one-cycle pulse marking a new valid result.
REQ-012 Port sum, output, WIDTH, registered result.
REQ-013 Port cout, output, 1, raw carry out of the MSB.
REQ-014 Port ovf, output, 1, signed overflow flag.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 In IDLE or DONE, start=1 SHALL capture a, b, cin and sub into internal registers and move the FSM to RUN on that edge.
REQ-017 In DONE, start=0 SHALL return the FSM to IDLE; the DONE state SHALL last exactly one cycle unless a new start is accepted.
REQ-018 In RUN, start and all operand inputs SHALL be ignored, so changing them mid-operation has no effect.
REQ-019 In RUN, each cycle SHALL add one CHUNK-bit slice, processing slices LSB first and passing the registered carry to the next slice.
REQ-020 Subtract SHALL be computed as a + ~b + ~cin; add SHALL be computed as a + b + cin.
REQ-021 After the last slice (slice index WIDTH/CHUNK-1), the FSM SHALL move to DONE and latch sum, cout and ovf on the same edge.
REQ-022 Latency: done SHALL be high exactly WIDTH/CHUNK cycles after the edge that accepted start; with the defaults this is 4 cycles.
REQ-023 busy SHALL be 1 exactly while the state is RUN, and done SHALL be 1 exactly while the state is DONE.
REQ-024 cout SHALL be the raw carry out of bit WIDTH-1, with no inversion in subtract mode.
REQ-025 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-026 sum, cout and ovf SHALL hold their values from the last completion until the next completion; partial sums SHALL NOT appear on sum.
REQ-027 Back-to-back operation: start=1 while in DONE SHALL be accepted, giving one result every WIDTH/CHUNK+1 cycles.
REQ-028 The result SHALL wrap modulo 2^WIDTH, and the carry SHALL appear only on cout.
REQ-029 Setting CHUNK=WIDTH SHALL give single-cycle RUN, with done high 1 cycle after start.

Reset
REQ-030 reset=1 SHALL take priority over start and force state IDLE, busy=0, done=0, sum=0, cout=0 and ovf=0 on the next edge.
REQ-031 reset asserted in RUN SHALL abort the operation and SHALL NOT produce a done pulse.
REQ-032 start=1 in the same cycle as reset=1 SHALL be ignored.

Verification (WIDTH=16, CHUNK=4)
REQ-033 The bench SHALL cover: a=0x1234, b=0x1111, cin=0, sub=0, one-cycle start -> busy high for 4 cycles, then done pulse with sum=0x2345, cout=0, ovf=0.
REQ-034 The bench SHALL cover: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-035 The bench SHALL cover: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-036 The bench SHALL cover: start held high continuously, with a and b changed during RUN -> one result every 5 cycles, each using the operands captured at acceptance.
REQ-037 The bench SHALL cover: reset pulsed in the 2nd RUN cycle -> no done pulse, all outputs 0, FSM in IDLE; the next start then completes normally.
REQ-038 The bench SHALL cover: the CHUNK=16 build with a=0x00FF, b=0x0001, cin=1 -> done 1 cycle after start, sum=0x0101.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per cycle, LSB slice first.
// Results appear only when the last slice completes and are held until the next one finishes.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CHUNK:0]   slice_sum;

    always_comb begin
        slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtract is folded in at capture: b and cin are stored inverted.
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                acc_d   = (acc_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = slice_sum[CHUNK];
                    // Same-sign operands producing an opposite-sign MSB is
                    // equivalent to carry-in(MSB) xor carry-out(MSB).
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                              (slice_sum[CHUNK-1] != a_q[CHUNK-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        acc_q   <= acc_d;
        carry_q <= carry_d;
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench for chunk_serial_adder: WIDTH=16 with CHUNK=4 and a CHUNK=16 build.
module tb_chunk_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start16;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    res_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub);
        logic [16:0] t;
        logic [15:0] bb;
        logic        cc;
        res_t        r;
        bb     = msub ? ~mb : mb;
        cc     = msub ? ~mcin : mcin;
        t      = {1'b0, ma} + {1'b0, bb} + {16'b0, cc};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (ma[15] == bb[15]) && (t[15] != ma[15]);
        return r;
    endfunction

    // Launches one operation on the CHUNK=4 instance, scrambles inputs during RUN,
    // and returns at the negedge where done is seen (or after a cycle budget).
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic isub, output int lat, output bit timeout, output bit held);
        logic [15:0] prev;
        @(negedge clk);
        prev  = sum;
        a     = ia;
        b     = ib;
        cin   = icin;
        sub   = isub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
        lat     = 0;
        timeout = 1'b1;
        held    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (busy === 1'b1) lat++;
            if (sum !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        start16 = 1'b1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, sum, cout, ovf} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        end
        vectors++;
        if ({busy16, done16, sum16, cout16, ovf16} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state16: busy=%b done=%b sum=%h, required all 0",
                     busy16, done16, sum16);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        start16 = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_ignored: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_add();
        res_t e;
        int   lat;
        bit   to, held;
        sb.push_back({16'h2345, 1'b0, 1'b0});
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, to, held);
        e = sb.pop_front();
        vectors++;
        if (to || lat != 4) begin
            miscompares++;
            $display("FAIL add_latency: busy cycles=%0d timeout=%0d, required 4 then done", lat, to);
        end
        vectors++;
        if ({busy, sum, cout, ovf} !== {1'b0, e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL add_result: busy=%b sum=%h cout=%b ovf=%b, required 0 %h %b %b",
                     busy, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, sum} !== {1'b0, 1'b0, e.sum}) begin
            miscompares++;
            $display("FAIL add_done_pulse: done=%b busy=%b sum=%h, required 0 0 %h",
                     done, busy, sum, e.sum);
        end
    endtask

    task automatic test_carry_ovf();
        res_t e;
        int   lat;
        bit   to, held;
        sb.push_back({16'h0000, 1'b1, 1'b0});
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, to, held);
        e = sb.pop_front();
        vectors++;
        if (to || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL add_wrap: sum=%h cout=%b ovf=%b timeout=%0d, required %h %b %b",
                     sum, cout, ovf, to, e.sum, e.cout, e.ovf);
        end
        sb.push_back({16'h8000, 1'b0, 1'b1});
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, to, held);
        e = sb.pop_front();
        vectors++;
        if (to || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL add_ovf: sum=%h cout=%b ovf=%b timeout=%0d, required %h %b %b",
                     sum, cout, ovf, to, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_sub();
        res_t e;
        int   lat;
        bit   to, held;
        sb.push_back({16'hFFFE, 1'b0, 1'b0});
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, to, held);
        e = sb.pop_front();
        vectors++;
        if (to || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL sub_neg: sum=%h cout=%b ovf=%b timeout=%0d, required %h %b %b",
                     sum, cout, ovf, to, e.sum, e.cout, e.ovf);
        end
        sb.push_back({16'h7FFF, 1'b1, 1'b1});
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, to, held);
        e = sb.pop_front();
        vectors++;
        if (to || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b timeout=%0d, required %h %b %b",
                     sum, cout, ovf, to, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_random();
        res_t        e;
        int          lat;
        bit          to, held;
        logic [15:0] ra, rb;
        logic        rc, rs;
        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            sb.push_back(model(ra, rb, rc, rs));
            run_op(ra, rb, rc, rs, lat, to, held);
            e = sb.pop_front();
            vectors++;
            if (to || !held || lat != 4) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: busy cycles=%0d held=%0d timeout=%0d, required 4 1 0",
                         k, lat, held, to);
            end
            vectors++;
            if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                miscompares++;
                $display("FAIL rand_result[%0d]: a=%h b=%h cin=%b sub=%b got %h %b %b, required %h %b %b",
                         k, ra, rb, rc, rs, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa[3] = '{16'h1000, 16'hA5A5, 16'h7FF0};
        logic [15:0] ob[3] = '{16'h0234, 16'h5A5A, 16'h0020};
        logic        oc[3] = '{1'b1, 1'b0, 1'b0};
        logic        os[3] = '{1'b0, 1'b1, 1'b0};
        res_t        e;
        logic        exp_done, exp_busy;
        for (int n = 0; n <= 16; n++) begin
            @(negedge clk);
            if (n > 0) begin
                exp_done = (n % 5 == 0) && (n <= 15);
                exp_busy = (n % 5 != 0) && (n < 16);
                vectors++;
                if ({done, busy} !== {exp_done, exp_busy}) begin
                    miscompares++;
                    $display("FAIL b2b_state[%0d]: done=%b busy=%b, required %b %b",
                             n, done, busy, exp_done, exp_busy);
                end
                if (exp_done && done === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    vectors++;
                    if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                        miscompares++;
                        $display("FAIL b2b_result[%0d]: got %h %b %b, required %h %b %b",
                                 n, sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (n % 5 == 0 && n / 5 < 3) begin
                a = oa[n/5]; b = ob[n/5]; cin = oc[n/5]; sub = os[n/5];
                start = 1'b1;
                sb.push_back(model(oa[n/5], ob[n/5], oc[n/5], os[n/5]));
            end else if (n >= 15) begin
                start = 1'b0;
            end else begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: %0d results outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_abort();
        res_t e;
        int   lat;
        bit   to, held, saw_done;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, sum, cout, ovf} !== 19'd0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL abort_no_done: activity seen after abort, required idle");
        end
        sb.push_back(model(16'h4321, 16'h1234, 1'b1, 1'b1));
        run_op(16'h4321, 16'h1234, 1'b1, 1'b1, lat, to, held);
        e = sb.pop_front();
        vectors++;
        if (to || lat != 4 || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL abort_recover: lat=%0d timeout=%0d got %h %b %b, required 4 0 %h %b %b",
                     lat, to, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_chunk16();
        res_t e;
        sb.push_back({16'h0101, 1'b0, 1'b0});
        sb.push_back({16'hFFFF, 1'b0, 1'b0});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a = 16'h00FF; b = 16'h0001; cin = 1'b1; sub = 1'b0;
            end else begin
                a = 16'h0000; b = 16'h0001; cin = 1'b0; sub = 1'b1;
            end
            start16 = 1'b1;
            @(posedge clk);
            #1;
            start16 = 1'b0;
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            vectors++;
            if ({busy16, done16} !== 2'b10) begin
                miscompares++;
                $display("FAIL c16_run[%0d]: busy=%b done=%b, required 1 0", k, busy16, done16);
            end
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({done16, busy16, sum16, cout16, ovf16} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
                miscompares++;
                $display("FAIL c16_result[%0d]: done=%b sum=%h cout=%b ovf=%b, required 1 %h %b %b",
                         k, done16, sum16, cout16, ovf16, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start16 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add();
        test_carry_ovf();
        test_sub();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_chunk16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
